// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the dual-port-RAM FIFO controller:
//   - fifo_state_e : occupancy FSM encoding (S_EMPTY / S_NORMAL / S_FULL)
//   - DEF_*        : default geometry and almost-full / almost-empty thresholds
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_NORMAL = 2'd1,
        S_FULL   = 2'd2
    } fifo_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_AF_THRESH = 56;
    localparam int DEF_AE_THRESH = 8;

endpackage : fifo_pkg

// File: rtl/fifo_flags.sv
// -----------------------------------------------------------------------------
// fifo_flags
// Threshold comparators for the FIFO occupancy count.
// Ports:
//   count_i        in  CNT_W  current occupancy
//   almost_full_o  out 1      count_i >= AF_THRESH
//   almost_empty_o out 1      count_i <= AE_THRESH
// Pure combinational decode of the registered count, so the flags carry the
// same timing as count itself.
// -----------------------------------------------------------------------------
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int CNT_W     = DEF_ADDR_W + 1,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic [CNT_W-1:0] count_i,
    output logic             almost_full_o,
    output logic             almost_empty_o
);

    // Thresholds sized to the count so the compare is unsigned and width-exact.
    localparam logic [CNT_W-1:0] AF_LIM = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LIM = CNT_W'(AE_THRESH);

    assign almost_full_o  = (count_i >= AF_LIM);
    assign almost_empty_o = (count_i <= AE_LIM);

endmodule : fifo_flags

// File: rtl/fifo_dpram_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_dpram_ctrl
// Synchronous FIFO controller driving an external simple dual-port RAM
// (port A write, port B one-cycle synchronous read).
// Ports:
//   clk, reset_L                     clock (rising edge), async active-low reset
//   push, data_in                    producer write request / data
//   pop                              consumer read request
//   data_out, valid_out              read data; valid_out pulses one cycle,
//                                    two cycles after the cycle pop was accepted
//   full, empty                      registered FSM flags
//   almost_full, almost_empty        count >= AF_THRESH / count <= AE_THRESH
//   count                            occupancy 0..2**ADDR_W
//   mem_we_a, mem_addr_a, mem_data_a RAM write port (combinational from push)
//   mem_we_b, mem_addr_b, mem_q_b    RAM read port (mem_we_b tied low)
// Build option:
//   FIFO_ERR_FLAGS_EN adds sticky outputs overflow / underflow, set by a
//   rejected push / pop and cleared only by reset_L.
// -----------------------------------------------------------------------------
module fifo_dpram_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              mem_we_a,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [DATA_W-1:0] mem_data_a,
    output logic              mem_we_b,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [DATA_W-1:0] mem_q_b
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    fifo_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q;
    logic              rd_pend_q;          // RAM read issued last edge
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              push_ok, pop_ok;

    // Pop never falls through an empty FIFO; push into a full FIFO is
    // accepted only when a pop frees the slot in the same cycle.
    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);

    assign mem_we_a   = push_ok;
    assign mem_addr_a = wr_ptr_q;
    assign mem_data_a = data_in;
    assign mem_we_b   = 1'b0;
    assign mem_addr_b = rd_ptr_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        // Pointers wrap naturally at 2**ADDR_W.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
        else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;

        case (state_q)
            S_EMPTY:  if (push_ok) state_d = S_NORMAL;
            S_NORMAL: begin
                if (count_d == DEPTH_CNT) state_d = S_FULL;
                else if (count_d == '0)   state_d = S_EMPTY;
            end
            S_FULL:   if (pop_ok && !push_ok) state_d = S_NORMAL;
            default:  state_d = S_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (state_d == S_EMPTY);
            full_q    <= (state_d == S_FULL);
            // Stage 1: RAM latches mem_addr_b; stage 2: capture mem_q_b.
            rd_pend_q <= pop_ok;
            valid_q   <= rd_pend_q;
            if (rd_pend_q) data_q <= mem_q_b;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !push_ok) overflow_q  <= 1'b1;
            if (pop && !pop_ok)   underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    fifo_flags #(
        .CNT_W     (ADDR_W + 1),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_flags (
        .count_i        (count_q),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty)
    );

    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule : fifo_dpram_ctrl
